// File: rtl/fm_dummy_pkg.sv
// Shared constants for the FM dummy monitor stream: signature words and checker state type.
// Used by both the dummy master and fm_dummy_checker.
package fm_dummy_pkg;

  localparam int unsigned FM_DUMMY_NUM_WORDS = 5;

  // Entry 0 is the first word on the stream; payload only, the marker bit is added by the sender.
  localparam logic [FM_DUMMY_NUM_WORDS-1:0][31:0] FM_DUMMY_VAL = {
    32'h7C00DEED, 32'h78000FAB, 32'h7000D0E5, 32'h60000BEE, 32'h40000BAD
  };

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StDone,
    StFail
  } fm_dummy_chk_state_t;

  function automatic logic [31:0] fm_dummy_word(input logic [2:0] k);
    case (k)
      3'd0:    fm_dummy_word = FM_DUMMY_VAL[0];
      3'd1:    fm_dummy_word = FM_DUMMY_VAL[1];
      3'd2:    fm_dummy_word = FM_DUMMY_VAL[2];
      3'd3:    fm_dummy_word = FM_DUMMY_VAL[3];
      3'd4:    fm_dummy_word = FM_DUMMY_VAL[4];
      default: fm_dummy_word = '0;
    endcase
  endfunction

endpackage

// File: rtl/fm_dummy_checker_if.sv
// FM monitor stream: valid/data, no backpressure.
interface fm_dummy_checker_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  mon_vld;
  logic [DATA_WIDTH-1:0] mon_data;

  modport master (output mon_vld, output mon_data);
  modport slave  (input mon_vld, input mon_data);

endinterface

// File: rtl/fm_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module fm_sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] cnt
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fm_dummy_checker.sv
// Receive-side checker for the FM dummy signature stream: lock, compare, count, time out.
// FM_DUMMY_CHK_CAPTURE_EN adds err_word/err_idx capture of the first offending word.
module fm_dummy_checker
  import fm_dummy_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  fm_dummy_checker_if.slave     mon,
  output logic                  locked,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      rx_cnt
`ifdef FM_DUMMY_CHK_CAPTURE_EN
  ,
  output logic [DATA_WIDTH-1:0] err_word,
  output logic [2:0]            err_idx
`endif
);

  localparam int unsigned IdleW    = $clog2(TIMEOUT);
  localparam logic [2:0]  LastIdx  = 3'(FM_DUMMY_NUM_WORDS - 1);
  localparam logic [2:0]  ExtraIdx = 3'(FM_DUMMY_NUM_WORDS);

  fm_dummy_chk_state_t state_q;
  logic [2:0]          idx_q;
  logic [IdleW-1:0]    idle_q;
  logic                locked_q, pass_q, fail_q, timeout_q;

  logic [DATA_WIDTH-1:0] exp_word;
  logic                  word_ok;
  logic                  idle_expired;
  logic                  rx_inc, err_inc;

  always_comb begin
    exp_word     = {1'b1, (DATA_WIDTH-1)'(fm_dummy_word(idx_q))};
    word_ok      = (mon.mon_data == exp_word);
    idle_expired = (idle_q == IdleW'(TIMEOUT - 1));
    rx_inc       = mon.mon_vld && !clr;
    err_inc      = mon.mon_vld && !clr &&
                   (((state_q == StCheck) && !word_ok) || (state_q == StDone));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      idle_q    <= '0;
      locked_q  <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else if (clr) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      idle_q    <= '0;
      locked_q  <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          // idx_q is 0 here, so exp_word is the first signature word
          if (mon.mon_vld && word_ok) begin
            state_q  <= StCheck;
            idx_q    <= 3'd1;
            idle_q   <= '0;
            locked_q <= 1'b1;
          end
        end
        StCheck: begin
          if (mon.mon_vld) begin
            if (!word_ok) begin
              state_q <= StFail;
              fail_q  <= 1'b1;
            end else if (idx_q == LastIdx) begin
              state_q <= StDone;
              pass_q  <= 1'b1;
            end else begin
              idx_q  <= idx_q + 3'd1;
              idle_q <= '0;
            end
          end else if (idle_expired) begin
            state_q   <= StFail;
            fail_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
        StDone: begin
          if (mon.mon_vld) begin
            state_q <= StFail;
            pass_q  <= 1'b0;
            fail_q  <= 1'b1;
          end
        end
        StFail:  ;
        default: state_q <= StIdle;
      endcase
    end
  end

  fm_sat_counter #(
    .Width (CNT_W)
  ) u_rx_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (rx_inc),
    .cnt (rx_cnt)
  );

  fm_sat_counter #(
    .Width (CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (err_inc),
    .cnt (err_cnt)
  );

  assign locked  = locked_q;
  assign pass    = pass_q;
  assign fail    = fail_q;
  assign timeout = timeout_q;

`ifdef FM_DUMMY_CHK_CAPTURE_EN
  logic [DATA_WIDTH-1:0] err_word_q;
  logic [2:0]            err_idx_q;
  logic                  enter_fail;

  // FAIL is terminal, so the first entry is the only one captured until clr/reset
  always_comb begin
    enter_fail = !clr &&
                 (((state_q == StCheck) && (mon.mon_vld ? !word_ok : idle_expired)) ||
                  ((state_q == StDone) && mon.mon_vld));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_word_q <= '0;
      err_idx_q  <= '0;
    end else if (clr) begin
      err_word_q <= '0;
      err_idx_q  <= '0;
    end else if (enter_fail) begin
      err_word_q <= mon.mon_vld ? mon.mon_data : '0;
      err_idx_q  <= (state_q == StDone) ? ExtraIdx : idx_q;
    end
  end

  assign err_word = err_word_q;
  assign err_idx  = err_idx_q;
`endif

endmodule

// File: tb/tb_fm_dummy_checker.sv
// Bench for fm_dummy_checker: vector table plus hand sequences, checked through a scoreboard queue.
module tb_fm_dummy_checker;

  localparam logic [31:0] W0 = 32'hC0000BAD;
  localparam logic [31:0] W1 = 32'hE0000BEE;
  localparam logic [31:0] W2 = 32'hF000D0E5;
  localparam logic [31:0] W3 = 32'hF8000FAB;
  localparam logic [31:0] W4 = 32'hFC00DEED;

  typedef struct {
    bit          vld;
    logic [31:0] data;
    bit          clr;
    bit          locked;
    bit          pass;
    bit          fail;
    bit          tmo;
    int          err;
    int          rx;
    logic [31:0] ew;
    int          ei;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       locked, pass, fail, timeout;
  logic [7:0] err_cnt, rx_cnt;
`ifdef FM_DUMMY_CHK_CAPTURE_EN
  logic [31:0] err_word;
  logic [2:0]  err_idx;
`endif

  fm_dummy_checker_if #(.DATA_WIDTH(32)) mon ();

  fm_dummy_checker #(
    .DATA_WIDTH (32),
    .TIMEOUT    (64),
    .CNT_W      (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .mon      (mon),
    .locked   (locked),
    .pass     (pass),
    .fail     (fail),
    .timeout  (timeout),
    .err_cnt  (err_cnt),
    .rx_cnt   (rx_cnt)
`ifdef FM_DUMMY_CHK_CAPTURE_EN
    ,
    .err_word (err_word),
    .err_idx  (err_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_total  = 0;
  int    n_passed = 0;
  string tname    = "reset";
  vec_t  sb[$];
  vec_t  tbl[$];
  vec_t  exp_v;

  function automatic void check(string what, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s/%s: got %0h, expected %0h at %0t", tname, what, act, exp, $time);
  endfunction

  function automatic vec_t mk(bit vld, logic [31:0] d, bit c, bit l, bit p, bit f, bit t,
                              int e, int r, logic [31:0] ew = 0, int ei = 0);
    vec_t v;
    v.vld = vld; v.data = d; v.clr = c;
    v.locked = l; v.pass = p; v.fail = f; v.tmo = t;
    v.err = e; v.rx = r; v.ew = ew; v.ei = ei;
    return v;
  endfunction

  // One cycle of stimulus; its expected post-edge status goes on the scoreboard.
  task automatic step(input vec_t v);
    @(negedge clk);
    mon.mon_vld  = v.vld;
    mon.mon_data = v.data;
    clr          = v.clr;
    sb.push_back(v);
  endtask

  task automatic check_zero();
    check("locked", locked, 0);
    check("pass", pass, 0);
    check("fail", fail, 0);
    check("timeout", timeout, 0);
    check("err_cnt", err_cnt, 0);
    check("rx_cnt", rx_cnt, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_v = sb.pop_front();
      check("locked", locked, exp_v.locked);
      check("pass", pass, exp_v.pass);
      check("fail", fail, exp_v.fail);
      check("timeout", timeout, exp_v.tmo);
      check("err_cnt", err_cnt, exp_v.err);
      check("rx_cnt", rx_cnt, exp_v.rx);
`ifdef FM_DUMMY_CHK_CAPTURE_EN
      check("err_word", err_word, exp_v.ew);
      check("err_idx", err_idx, exp_v.ei);
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // good sequence, extra word, word in FAIL, clr drops its word
    tbl.push_back(mk(1, W0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, W1, 0, 1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, W2, 0, 1, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, W3, 0, 1, 0, 0, 0, 0, 4));
    tbl.push_back(mk(1, W4, 0, 1, 1, 0, 0, 0, 5));
    tbl.push_back(mk(0, 0,  0, 1, 1, 0, 0, 0, 5));
    tbl.push_back(mk(1, W0, 0, 1, 0, 1, 0, 1, 6, W0, 5));
    tbl.push_back(mk(1, W1, 0, 1, 0, 1, 0, 1, 7, W0, 5));
    tbl.push_back(mk(1, W0, 1, 0, 0, 0, 0, 0, 0));
    // garbage before lock, then good sequence with a gap
    tbl.push_back(mk(1, 32'h0,        0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 32'h12345678, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 32'h40000BAD, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, W0, 0, 1, 0, 0, 0, 0, 4));
    tbl.push_back(mk(1, W1, 0, 1, 0, 0, 0, 0, 5));
    tbl.push_back(mk(0, 0,  0, 1, 0, 0, 0, 0, 5));
    tbl.push_back(mk(1, W2, 0, 1, 0, 0, 0, 0, 6));
    tbl.push_back(mk(1, W3, 0, 1, 0, 0, 0, 0, 7));
    tbl.push_back(mk(1, W4, 0, 1, 1, 0, 0, 0, 8));
    tbl.push_back(mk(0, 0,  1, 0, 0, 0, 0, 0, 0));
    // payload mismatch on word index 2, then FAIL stays put
    tbl.push_back(mk(1, W0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, W1, 0, 1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 32'hF000D0E4, 0, 1, 0, 1, 0, 1, 3, 32'hF000D0E4, 2));
    tbl.push_back(mk(1, W3, 0, 1, 0, 1, 0, 1, 4, 32'hF000D0E4, 2));
    tbl.push_back(mk(0, 0,  1, 0, 0, 0, 0, 0, 0));
    // marker bit missing on word index 1
    tbl.push_back(mk(1, W0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 32'h60000BEE, 0, 1, 0, 1, 0, 1, 2, 32'h60000BEE, 1));
    tbl.push_back(mk(0, 0,  1, 0, 0, 0, 0, 0, 0));
    // clr with a valid word mid-sequence, then restart
    tbl.push_back(mk(1, W0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, W1, 0, 1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, W2, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, W0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, W1, 0, 1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, W2, 0, 1, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, W3, 0, 1, 0, 0, 0, 0, 4));
    tbl.push_back(mk(1, W4, 0, 1, 1, 0, 0, 0, 5));

    rst          = 1'b0;
    clr          = 1'b0;
    mon.mon_vld  = 1'b0;
    mon.mon_data = '0;
    #3;
    check_zero();
    #9;
    rst = 1'b1;
    #1;
    check_zero();

    tname = "table";
    foreach (tbl[i]) step(tbl[i]);

    // silence for TIMEOUT cycles after word 2 -> timeout on the 64th edge
    tname = "timeout";
    step(mk(0, 0,  1, 0, 0, 0, 0, 0, 0));
    step(mk(1, W0, 0, 1, 0, 0, 0, 0, 1));
    step(mk(1, W1, 0, 1, 0, 0, 0, 0, 2));
    for (int i = 0; i < 63; i++) step(mk(0, 0, 0, 1, 0, 0, 0, 0, 2));
    step(mk(0, 0,  0, 1, 0, 1, 1, 0, 2, 0, 2));
    step(mk(1, W2, 0, 1, 0, 1, 1, 0, 3, 0, 2));

    // word 3 lands exactly on the 64th cycle and beats the timeout
    tname = "timeout_edge";
    step(mk(0, 0,  1, 0, 0, 0, 0, 0, 0));
    step(mk(1, W0, 0, 1, 0, 0, 0, 0, 1));
    step(mk(1, W1, 0, 1, 0, 0, 0, 0, 2));
    for (int i = 0; i < 63; i++) step(mk(0, 0, 0, 1, 0, 0, 0, 0, 2));
    step(mk(1, W2, 0, 1, 0, 0, 0, 0, 3));
    step(mk(1, W3, 0, 1, 0, 0, 0, 0, 4));
    step(mk(1, W4, 0, 1, 1, 0, 0, 0, 5));
    step(mk(0, 0,  0, 1, 1, 0, 0, 0, 5));

    // asynchronous reset pulse mid-sequence
    tname = "async_rst";
    step(mk(0, 0,  1, 0, 0, 0, 0, 0, 0));
    step(mk(1, W0, 0, 1, 0, 0, 0, 0, 1));
    step(mk(1, W1, 0, 1, 0, 0, 0, 0, 2));
    @(posedge clk);
    #2;
    mon.mon_vld = 1'b0;
    rst         = 1'b0;
    #1;
    check_zero();
    rst = 1'b1;
    step(mk(1, W0, 0, 1, 0, 0, 0, 0, 1));
    step(mk(1, W1, 0, 1, 0, 0, 0, 0, 2));
    step(mk(1, W2, 0, 1, 0, 0, 0, 0, 3));
    step(mk(1, W3, 0, 1, 0, 0, 0, 0, 4));
    step(mk(1, W4, 0, 1, 1, 0, 0, 0, 5));
    step(mk(0, 0,  0, 1, 1, 0, 0, 0, 5));

    @(posedge clk);
    #3;
    tname = "drain";
    check("scoreboard_left", sb.size(), 0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/fm_dummy_checker.md
Name: fm_dummy_checker

Overview:
Receive-side checker for the FM dummy monitor stream. It consumes the valid/data stream emitted by the dummy master, locks onto the fixed 5-word signature sequence, and compares every word against that sequence. It reports pass/fail, error and word counts, and a timeout. It sits at the FM monitor sink and gives a link self-test before real spy data is trusted.

Parameters:
DATA_WIDTH, 32, stream word width; bit DATA_WIDTH-1 is the marker bit, bits DATA_WIDTH-2:0 are payload
TIMEOUT, 64, maximum idle cycles allowed between words once locked (>=2)
CNT_W, 8, width of the saturating counters rx_cnt and err_cnt

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
clr  in  1  synchronous clear; returns the block to IDLE and zeroes all status
mon_data  in  DATA_WIDTH  monitor stream data
mon_vld  in  1  monitor stream valid; no backpressure
locked  out  1  first signature word seen; checking in progress or finished
pass  out  1  all 5 words received in order with no error (sticky)
fail  out  1  mismatch, extra word or timeout (sticky)
timeout  out  1  fail was caused by timeout (sticky)
err_cnt  out  CNT_W  mismatches and extra words, saturating
rx_cnt  out  CNT_W  valid words received in any state, saturating

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, idx=0, idle counter=0, all outputs 0.
- Expected word k: marker=1, payload = FM_DUMMY_VAL[k] truncated to DATA_WIDTH-1 bits, for k=0..4.
- All status outputs are registered and update on the clock edge that samples mon_vld=1. There is no further latency.
- rx_cnt increments on every mon_vld=1 cycle in every state. It saturates at 2^CNT_W-1.
- FSM states: IDLE, CHECK, DONE, FAIL.
  - IDLE: if mon_vld=1 and the word equals expected word 0, go to CHECK with idx=1 and locked=1. Any other valid word is ignored: no error, counted in rx_cnt only.
  - CHECK, mon_vld=1, word equals expected[idx]:
    - idx<4: idx++ and the idle counter resets.
    - idx==4: go to DONE and set pass=1.
  - CHECK, mon_vld=1, word mismatches: err_cnt++ and go to FAIL.
  - CHECK, mon_vld=0: the idle counter increments. When it reaches TIMEOUT-1 and mon_vld is still 0, go to FAIL with timeout=1. A word arriving on that same cycle is checked normally and takes precedence.
  - DONE: any mon_vld=1 is an extra word. err_cnt++, pass clears, fail sets, go to FAIL.
  - FAIL: terminal until clr or reset. mon_vld=1 in FAIL increments rx_cnt only; err_cnt is unchanged.
- clr=1: next state IDLE; idx, idle counter, pass, fail, timeout, locked, err_cnt and rx_cnt all zeroed. clr has priority over a simultaneous mon_vld, and that word is dropped without being counted.
- pass and fail are never both 1.
- A marker-bit mismatch counts as a data mismatch.

Optional Feature:
Macro FM_DUMMY_CHK_CAPTURE_EN.
- Defined: adds outputs err_word (DATA_WIDTH) and err_idx (3 bits). These capture the first offending word and the expected index (5 for an extra word) on the transition into FAIL. They hold until clr or reset, and reset to 0.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Decomposition:
- Package fm_dummy_pkg holds:
  - FM_DUMMY_NUM_WORDS=5
  - the FM_DUMMY_VAL constant array {'h40000BAD,'h60000BEE,'h7000D0E5,'h78000FAB,'h7C00DEED}
  - the fm_dummy_chk_state_t enum
- The dummy master is migrated to use the same package constants.
- One sub-module: fm_sat_counter (parameterised width, inc, clr, asynchronous active-low reset). It is instantiated for rx_cnt and err_cnt.

Test Plan:
1. Reset release, then the 5 master words back-to-back ('hC0000BAD, 'hE0000BEE, 'hF000D0E5, 'hF8000FAB, 'hFC00DEED) -> pass=1 on the edge of word 5, fail=0, rx_cnt=5, err_cnt=0, locked=1.
2. Three garbage words ('h0, 'h12345678, 'h40000BAD without marker), then the good sequence -> no error, locked rises on 'hC0000BAD, pass=1, rx_cnt=8.
3. Sequence with word 3 = 'hF000D0E4 -> fail=1 on that edge, err_cnt=1, pass=0; with FM_DUMMY_CHK_CAPTURE_EN, err_word='hF000D0E4 and err_idx=2.
4. Two words, then mon_vld held low for TIMEOUT=64 cycles -> fail=1 and timeout=1 exactly 64 cycles after word 2; err_cnt=0. Repeat with word 3 arriving on cycle 64 -> no timeout.
5. Full pass followed by one extra valid word -> pass drops, fail=1, err_cnt=1, rx_cnt=6; with capture enabled, err_idx=5.
6. clr asserted with mon_vld=1 mid-sequence, and rst pulsed low asynchronously mid-sequence -> both return to IDLE with all outputs 0 and the clr-cycle word not counted; a subsequent good sequence gives pass=1.
